sum_out_fifo: RTL and testbench
===============================

SUM_OUT_FIFO -- requirements
Module: sum_out_fifo

Interface
REQ-001 Parameter: DEPTH, default 4, FIFO entry count; SHALL be a power of two, 2..16.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: sum_in  input  10  accumulated sum from the upstream 4-sample accumulator.
REQ-005 Port: sum_valid  input  1  single-cycle strobe; sum_in is valid this cycle; no backpressure to upstream.
REQ-006 Port: data_out  output  10  head-of-FIFO word, first-word-fall-through.
REQ-007 Port: out_valid  output  1  data_out holds a valid word.
REQ-008 Port: out_ready  input  1  consumer accepts; pop occurs when out_valid && out_ready.
REQ-009 Port: level  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-010 Port: full  output  1  level == DEPTH.
REQ-011 Port: overflow  output  1  sticky flag; a sum was dropped.
REQ-012 Port: clr_ovf  input  1  clears overflow.

Function
REQ-013 Storage SHALL be DEPTH x 10-bit registers with wrap-around read/write pointers of clog2(DEPTH) bits.
REQ-014 Push SHALL occur when sum_valid && (!full || pop) in the same cycle.
REQ-015 Pop SHALL occur when out_valid && out_ready; out_valid SHALL equal (level != 0) and be driven from registered state only.
REQ-016 data_out SHALL equal the entry at the read pointer when out_valid=1, and SHALL be 0 when out_valid=0.
REQ-017 Latency: a sum pushed into an empty FIFO in cycle N SHALL appear with out_valid=1 in cycle N+1.
REQ-018 Level update: push only +1; pop only -1; push and pop together leave level unchanged.
REQ-019 Full with simultaneous pop: the push SHALL be accepted and overflow SHALL NOT be set.
REQ-020 Empty with simultaneous sum_valid: no pop occurs (out_valid=0); the word is written, level becomes 1.
REQ-021 Full without pop and sum_valid=1: sum_in SHALL be discarded; FIFO contents and pointers unchanged; overflow set to 1 next cycle.
REQ-022 overflow SHALL stay 1 until clr_ovf=1; when a drop and clr_ovf coincide, set SHALL win.
REQ-023 Word order at the output SHALL match push order; no entry SHALL be duplicated or skipped across pointer wrap.
REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-025 While rst=1 at a clock edge: pointers=0, level=0, overflow=0, out_valid=0, full=0, data_out=0.
REQ-026 Reset mid-operation SHALL discard all stored words; sum_valid during the reset cycle SHALL be ignored.
REQ-027 Storage registers need not be reset; outputs SHALL NOT expose them while level=0.

Configuration
REQ-028 Macro SUM_OUT_FIFO_AVG_EN: when defined, data_out[7:0] SHALL be stored_sum[9:2] (mean of 4 samples, truncated) and data_out[9:8]=0.
REQ-029 Without SUM_OUT_FIFO_AVG_EN, data_out SHALL be the raw 10-bit stored sum; all other behaviour identical in both builds.

Verification
REQ-030 Reset, then sum_valid pulse with sum_in=10'd600, out_ready=0 -> next cycle out_valid=1, data_out=600 (150 with AVG_EN), level=1.
REQ-031 Push 4 sums 1,2,3,4 with out_ready=0, then 5th sum 9 -> full=1, level=4, overflow=1; drain yields 1,2,3,4 only.
REQ-032 Full FIFO, out_ready=1 and sum_valid with sum_in=7 same cycle -> level stays 4, overflow stays 0, 7 emerges last.
REQ-033 out_ready held 1, 10 pushes of 100..109 one per 4 cycles -> outputs 100..109 in order, each 1 cycle after push, level never exceeds 1.
REQ-034 overflow=1, clr_ovf=1 coincident with a drop -> overflow remains 1; clr_ovf next cycle with no drop -> overflow=0.
REQ-035 Level=3, rst=1 for one cycle with sum_valid=1 -> level=0, out_valid=0, data_out=0, overflow=0 after the edge.

Source files
------------

// File: rtl/sum_out_fifo.sv
// sum_out_fifo: first-word-fall-through FIFO buffering accumulated sums from the
// 4-sample accumulator. Upstream has no backpressure, so a push into a full FIFO
// with no simultaneous pop drops the word and raises a sticky overflow flag.
// Optional build macro SUM_OUT_FIFO_AVG_EN: present the stored sum divided by 4
// (truncated) on data_out instead of the raw 10-bit sum.
module sum_out_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [9:0]                 sum_in,
  input  logic                       sum_valid,
  output logic [9:0]                 data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  logic          push;
  logic          pop;
  logic          drop;
  logic [9:0]    head;

  // Handshake decode; status flags come from registered state only.
  always_comb begin
    out_valid = (level_q != '0);
    full      = (level_q == LW'(DEPTH));
    pop       = out_valid && out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    push      = sum_valid && (!full || pop);
    drop      = sum_valid && full && !pop;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Set wins over clear when a drop and clr_ovf coincide.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array, intentionally not reset; masked at the output while empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= sum_in;
    end
  end

  // Output formatting of the head word.
  always_comb begin
    head = mem_q[rd_ptr_q];
    if (!out_valid) begin
      data_out = '0;
    end else begin
`ifdef SUM_OUT_FIFO_AVG_EN
      data_out = {2'b00, head[9:2]};
`else
      data_out = head;
`endif
    end
    level    = level_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_sum_out_fifo.sv
// Self-checking bench for sum_out_fifo: directed steps with a scoreboard queue
// holding the words expected at the FIFO head, in push order.
module tb_sum_out_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] sum_in;
  logic       sum_valid;
  logic [9:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] level;
  logic       full;
  logic       overflow;
  logic       clr_ovf;

  int checks = 0;
  int errors = 0;

  logic [9:0] sb[$];
  int         mlev = 0;
  logic       movf = 1'b0;

  always #5 clk = ~clk;

  sum_out_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sum_in    (sum_in),
    .sum_valid (sum_valid),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  function automatic logic [9:0] expv(input logic [9:0] v);
`ifdef SUM_OUT_FIFO_AVG_EN
    return {2'b00, v[9:2]};
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, update the model for this cycle's
  // inputs, then advance one clock and settle.
  task automatic step();
    logic       pop_m;
    logic       push_m;
    logic       drop_m;
    logic [9:0] head_m;
    head_m = (mlev != 0) ? sb[0] : 10'd0;
    chk("out_valid", {31'd0, out_valid}, {31'd0, mlev != 0});
    chk("level", {29'd0, level}, mlev);
    chk("full", {31'd0, full}, {31'd0, mlev == DEPTH});
    chk("overflow", {31'd0, overflow}, {31'd0, movf});
    chk("data_out", {22'd0, data_out}, {22'd0, head_m});
    pop_m  = (mlev != 0) && out_ready;
    push_m = sum_valid && ((mlev < DEPTH) || pop_m);
    drop_m = sum_valid && !push_m;
    if (rst) begin
      sb.delete();
      mlev = 0;
      movf = 1'b0;
    end else begin
      if (pop_m) void'(sb.pop_front());
      if (push_m) sb.push_back(expv(sum_in));
      mlev = mlev + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
      if (drop_m) movf = 1'b1;
      else if (clr_ovf) movf = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [9:0] v);
    sum_valid = 1'b1;
    sum_in    = v;
    step();
    sum_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    sum_in    = '0;
    sum_valid = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_data", {22'd0, data_out}, 32'd0);

    // Single push, one-cycle latency.
    push_one(10'd600);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", {22'd0, data_out}, {22'd0, expv(10'd600)});
    chk("lat_level", {29'd0, level}, 32'd1);
    out_ready = 1'b1;
    step();
    step();  // ready while empty has no effect
    out_ready = 1'b0;

    // Fill, then drop one.
    for (int i = 1; i <= 4; i++) push_one(10'(i));
    push_one(10'd9);
    chk("ovf_full", {31'd0, full}, 32'd1);
    chk("ovf_level", {29'd0, level}, 32'd4);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_head", {22'd0, data_out}, {22'd0, expv(10'd1)});
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    out_ready = 1'b0;
    chk("drain_level", {29'd0, level}, 32'd0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clr", {31'd0, overflow}, 32'd0);

    // Full with simultaneous pop and push.
    for (int i = 10; i <= 13; i++) push_one(10'(i));
    out_ready = 1'b1;
    push_one(10'd7);
    chk("fpp_level", {29'd0, level}, 32'd4);
    chk("fpp_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 5; i++) step();

    // Streaming with consumer always ready.
    for (int i = 0; i < 10; i++) begin
      push_one(10'(100 + i));
      chk("str_valid", {31'd0, out_valid}, 32'd1);
      chk("str_data", {22'd0, data_out}, {22'd0, expv(10'(100 + i))});
      chk("str_level1", {29'd0, level}, 32'd1);
      for (int j = 0; j < 3; j++) begin
        step();
        chk("str_level_le1", {31'd0, level <= 3'd1}, 32'd1);
      end
    end
    out_ready = 1'b0;

    // Set wins over clear.
    for (int i = 0; i < 4; i++) push_one(10'(1000 + i));
    push_one(10'd5);
    clr_ovf = 1'b1;
    push_one(10'd6);
    chk("setwins", {31'd0, overflow}, 32'd1);
    step();
    clr_ovf = 1'b0;
    chk("clr_after", {31'd0, overflow}, 32'd0);
    push_one(10'd8);
    chk("reovf", {31'd0, overflow}, 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pre_rst_level", {29'd0, level}, 32'd3);

    // Mid-operation reset with sum_valid asserted.
    rst       = 1'b1;
    sum_valid = 1'b1;
    sum_in    = 10'd55;
    step();
    rst       = 1'b0;
    sum_valid = 1'b0;
    chk("mrst_level", {29'd0, level}, 32'd0);
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_data", {22'd0, data_out}, 32'd0);
    chk("mrst_ovf", {31'd0, overflow}, 32'd0);
    step();
    push_one(10'd321);
    chk("post_rst_data", {22'd0, data_out}, {22'd0, expv(10'd321)});
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
